// File: rtl/piso_serializer.sv
// piso_serializer: MSB-first parallel-to-serial converter with a one-word holding
// buffer so consecutive words stream without gap cycles.
module piso_serializer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t           state;
    logic [WIDTH-1:0] hold, sreg;
    logic [CW-1:0]    cnt;
    logic             hold_full, xfer, last, load, step, hold_next, shift_next;
    // in_ready mirrors !hold_full, so a transfer and a reload never share an edge
    assign xfer       = in_valid && in_ready;
    assign last       = cnt == CW'(WIDTH - 1);
    assign load       = hold_full && (state == IDLE || last);
    assign step       = state == SHIFT && !last;
    assign hold_next  = xfer || (hold_full && !load);
    assign shift_next = load || step;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            hold         <= '0;
            hold_full    <= 1'b0;
            sreg         <= '0;
            cnt          <= '0;
            in_ready     <= 1'b0;
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
            frame_start  <= 1'b0;
            frame_end    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            if (xfer) hold <= in_data;
            hold_full    <= hold_next;
            in_ready     <= !hold_next;
            busy         <= shift_next || hold_next;
            state        <= shift_next ? SHIFT : IDLE;
            sreg         <= load ? hold : step ? sreg << 1 : '0;
            cnt          <= step ? cnt + CW'(1) : '0;
            // outputs present the bit that sreg will hold after this edge
            serial_valid <= shift_next;
            serial_out   <= load ? hold[WIDTH-1] : step && sreg[WIDTH-2];
            frame_start  <= load;
            frame_end    <= step && cnt == CW'(WIDTH - 2);
        end
    end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: scoreboard bench; a cycle-stamped reference model predicts
// every serial bit, which a negedge monitor pops and compares.
module tb_piso_serializer;
    localparam int W = 4;
    logic         clk = 1'b0, rst_n = 1'b1;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready, serial_out, serial_valid, frame_start, frame_end, busy;
    logic [7:0]   in_data8 = '0;
    logic         in_valid8 = 1'b0;
    logic         in_ready8, serial_out8, serial_valid8, frame_start8, frame_end8, busy8;

    piso_serializer #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .serial_out(serial_out), .serial_valid(serial_valid),
        .frame_start(frame_start), .frame_end(frame_end), .busy(busy)
    );
    piso_serializer #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data8), .in_valid(in_valid8),
        .in_ready(in_ready8), .serial_out(serial_out8), .serial_valid(serial_valid8),
        .frame_start(frame_start8), .frame_end(frame_end8), .busy(busy8)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           cyc;
        logic         b;
        logic         fs;
        logic         fe;
        logic [W-1:0] word;
    } exp_t;
    exp_t         q[$];
    exp_t         e;
    int           checks = 0, errors = 0;
    int           cyc = 0, hold_drain = 0, shift_end = 0, st = 0;
    logic         ready_m = 1'b0, busy_m = 1'b0, mon_en = 1'b0;
    logic [W-1:0] sipo = '0;
    logic [7:0]   got8 = '0;
    int           nb8 = 0, fe_at = -1, fs_at = -1;
    logic         r8 = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, want);
        end
    endtask

    // Word accepted at edge t starts at max(t+1, end of previous word); hold empties at start.
    initial forever begin
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            q.delete();
            hold_drain = 0;
            shift_end  = 0;
            ready_m    = 1'b0;
            busy_m     = 1'b0;
        end else begin
            if (in_valid && ready_m) begin
                st = (cyc + 1 > shift_end) ? cyc + 1 : shift_end;
                for (int i = 0; i < W; i++)
                    q.push_back('{st + i, in_data[W-1-i], i == 0, i == W - 1, in_data});
                hold_drain = st;
                shift_end  = st + W;
            end
            ready_m = cyc >= hold_drain;
            busy_m  = cyc < shift_end;
        end
    end

    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            if (!rst_n) begin
                chk("reset_outputs", 32'({in_ready, serial_out, serial_valid, frame_start, frame_end, busy}), 0);
            end else begin
                chk("in_ready", 32'(in_ready), 32'(ready_m));
                chk("busy", 32'(busy), 32'(busy_m));
                sipo = {sipo[W-2:0], serial_out};
                if (serial_valid || (q.size() > 0 && q[0].cyc == cyc)) begin
                    if (q.size() == 0) chk("unexpected_bit", 32'(serial_valid), 0);
                    else begin
                        e = q.pop_front();
                        chk("bit_cycle", cyc, e.cyc);
                        chk("bit", 32'({serial_valid, serial_out, frame_start, frame_end}),
                            32'({1'b1, e.b, e.fs, e.fe}));
                        if (e.fe) chk("downstream_word", 32'(sipo), 32'(e.word));
                    end
                end else chk("idle_outputs", 32'({serial_out, frame_start, frame_end}), 0);
            end
        end
    end

    task automatic send(input logic [W-1:0] d);
        logic r = 1'b0;
        in_data  = d;
        in_valid = 1'b1;
        for (int n = 0; n < 50 && !r; n++) begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
        end
        if (!r) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: in_ready stayed 0, expected 1");
        end
        #2;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        mon_en = 1'b1;
        #1 chk("async_reset", 32'({in_ready, serial_out, serial_valid, frame_start, frame_end, busy}), 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        send(4'b1011);
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        send(4'b1011);
        send(4'b0110);
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        // pulses below land while in_ready is low and must be dropped
        send(4'b0101);
        in_data = 4'b1111;
        @(posedge clk);
        #2 in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        send(4'b1100);
        send(4'b0011);
        in_data = 4'b1111;
        @(posedge clk);
        #2 in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #2;
        repeat (300) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = W'($urandom);
            @(posedge clk);
            #2;
        end
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #2;
        send(4'b1011);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 chk("midword_active", 32'(serial_valid), 1);
        rst_n = 1'b0;
        #1 chk("midword_reset", 32'({serial_out, serial_valid}), 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #2;
        send(4'b0001);
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        in_data8  = 8'hA5;
        in_valid8 = 1'b1;
        for (int n = 0; n < 50 && !r8; n++) begin
            @(negedge clk);
            r8 = in_ready8;
            @(posedge clk);
        end
        #2 in_valid8 = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (serial_valid8) begin
                got8 = {got8[6:0], serial_out8};
                if (frame_end8) fe_at = nb8;
                if (frame_start8) fs_at = nb8;
                nb8++;
            end
        end
        chk("w8_bits", 32'(got8), 32'h0000_00A5);
        chk("w8_count", nb8, 8);
        chk("w8_frame_start", fs_at, 0);
        chk("w8_frame_end", fe_at, 7);
        repeat (5) @(posedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out serializer that converts WIDTH-bit words into an MSB-first bit stream, one bit per clock. It sits directly upstream of the 4-bit serial-in/parallel-out shift register: serial_out drives that register's serial_in, and after WIDTH bits the register's parallel_out equals the word that was sent. A one-word holding buffer accepts the next word while the current one is shifting, so consecutive words stream with no gap cycles.

## Interface

- WIDTH, 4: word width in bits. Must be ≥ 2.
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_data  input  WIDTH  parallel word to serialize.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  holding buffer is empty. Registered.
- serial_out  output  1  serial bit, MSB first; 0 whenever serial_valid=0.
- serial_valid  output  1  serial_out carries a data bit this cycle.
- frame_start  output  1  high during the cycle that carries bit WIDTH-1 of a word.
- frame_end  output  1  high during the cycle that carries bit 0 of a word.
- busy  output  1  shifter is in SHIFT or the holding buffer is full.

## Operation

- Transfer: a word transfers on a rising edge where in_valid=1 and in_ready=1. in_data is copied into hold and hold_full is set. If in_ready=0, in_data is ignored.
- in_ready next-state = !hold_full next-state. There is no combinational path from in_valid to in_ready.
- State machine states:
  - IDLE: serial_valid=0, serial_out=0.
  - SHIFT: one bit is output per cycle. Bit counter cnt runs from 0 to WIDTH-1 (width clog2(WIDTH)), and serial_out carries bit WIDTH-1-cnt.
- IDLE→SHIFT: on an edge where hold_full=1. Loads sreg←hold, cnt←0, clears hold_full, and asserts frame_start for that cycle.
- SHIFT, cnt<WIDTH-1: cnt increments and sreg shifts left by one.
- SHIFT, cnt==WIDTH-1 (last bit on output):
  - If hold_full=1, reload sreg from hold, set cnt←0, stay in SHIFT, and assert frame_start. There is no gap cycle.
  - Otherwise go to IDLE.
- Simultaneous transfer and drain on the same edge cannot occur: a transfer needs in_ready=1, which means hold was already empty.
- An in_valid pulse while hold_full=1 is dropped. Upstream must hold in_valid until it sees in_ready.
- in_data changing while in_ready=0 has no effect.
- Reset asserted at any time, including mid-word:
  - All outputs go to their reset values immediately.
  - The shifting word and any held word are discarded.
  - Partial output is not resumed after reset.

## Timing

- Reset values: in_ready=0, serial_out=0, serial_valid=0, frame_start=0, frame_end=0, busy=0; state=IDLE, hold_full=0, cnt=0, sreg=0.
- in_ready rises on the first rising edge after rst_n deasserts.
- All outputs are registered.
- Latency: a word transferred at edge N, with the shifter idle, presents its MSB from edge N+1. Its LSB is presented from edge N+WIDTH, with frame_end high in that cycle.
- in_ready is low from edge N to N+1 (one cycle), then high again.
- Downstream register (samples serial_in on the rising edge): after the edge that ends the frame_end cycle, its low WIDTH bits equal the transferred word.
- Throughput: one word per WIDTH cycles. serial_valid stays continuously high as long as each next word is transferred at least one edge before the current word's last-bit edge.
- busy falls on the edge that moves the shifter to IDLE with hold empty.

## Test plan

- Reset and release: assert rst_n=0 mid-cycle.
  - All outputs go to 0 asynchronously.
  - After release, in_ready=1 after the first edge; serial_valid stays 0 with no input.
- Single word 4'b1011, transferred at edge N:
  - serial_out = 1,0,1,1 during cycles N+1..N+4, serial_valid high for exactly those 4 cycles.
  - frame_start high only in cycle N+1; frame_end high only in cycle N+4.
  - Downstream parallel_out = 4'b1011.
- Back-to-back 1011 then 0110, in_valid held high with each word presented until transferred:
  - serial_out = 1,0,1,1,0,1,1,0 over 8 contiguous cycles with serial_valid never low.
  - Downstream parallel_out = 4'b0110 at the end.
- in_valid pulsed with 4'b1111 while in_ready=0: the word is never output and the stream is unchanged.
- Reset mid-word: send 4'b1011 and assert rst_n=0 after 2 bits.
  - serial_out and serial_valid drop to 0 immediately.
  - After release, the next word 4'b0001 is output cleanly as 0,0,0,1.
- WIDTH=8, word 8'hA5: serial_out = 1,0,1,0,0,1,0,1, frame_end in the 8th cycle.
